// File: rtl/div_share_arbiter_if.sv
// Bundle of requester-side and divider-side signals for div_share_arbiter.
// The arbiter connects through modport slave; the environment drives modport master.
interface div_share_arbiter_if;
    logic [1:0]  req_i;
    logic [31:0] a0_i;
    logic [31:0] a1_i;
    logic [15:0] b0_i;
    logic [15:0] b1_i;
    logic [1:0]  ack_o;
    logic        rsp_valid_o;
    logic        rsp_id_o;
    logic [31:0] rsp_q_o;
    logic [15:0] rsp_r_o;
    logic        rsp_dz_o;
    logic        busy_o;
    logic [31:0] div_a_o;
    logic [15:0] div_b_o;
    logic        div_start_o;
    logic [31:0] div_q_i;
    logic [15:0] div_r_i;
    logic        div_ready_i;
    logic        div_busy_i;

    modport slave (
        input  req_i, a0_i, a1_i, b0_i, b1_i,
        input  div_q_i, div_r_i, div_ready_i, div_busy_i,
        output ack_o, rsp_valid_o, rsp_id_o, rsp_q_o, rsp_r_o, rsp_dz_o, busy_o,
        output div_a_o, div_b_o, div_start_o
    );

    modport master (
        output req_i, a0_i, a1_i, b0_i, b1_i,
        output div_q_i, div_r_i, div_ready_i, div_busy_i,
        input  ack_o, rsp_valid_o, rsp_id_o, rsp_q_o, rsp_r_o, rsp_dz_o, busy_o,
        input  div_a_o, div_b_o, div_start_o
    );
endinterface

// File: rtl/div_share_arbiter.sv
// Round-robin two-port sequencer in front of one shared 32/16 divider.
// Optional macro DIV_ZERO_BYPASS_EN answers zero divisors without using the divider.
module div_share_arbiter (
    input  logic               clock,
    input  logic               resetn,
    div_share_arbiter_if.slave bus
);
    typedef enum logic [1:0] {StIdle, StLaunch, StWait, StResp} state_e;

    state_e      r_state;
    state_e      w_state_nxt;
    logic        r_last_grant;
    logic        r_id;
    logic [31:0] r_op_a;
    logic [15:0] r_op_b;
    logic [31:0] r_q;
    logic [15:0] r_r;
    logic        w_win;
    logic        w_grant;
    logic        w_bypass;
    logic [31:0] w_sel_a;
    logic [15:0] w_sel_b;
`ifdef DIV_ZERO_BYPASS_EN
    logic        r_dz;
`endif

    // Contention goes to the requester not granted last.
    always_comb begin
        w_win = ~r_last_grant;
        case (bus.req_i)
            2'b01:   w_win = 1'b0;
            2'b10:   w_win = 1'b1;
            default: w_win = ~r_last_grant;
        endcase
        w_grant = (r_state == StIdle) && (bus.req_i != 2'b00);
        w_sel_a = w_win ? bus.a1_i : bus.a0_i;
        w_sel_b = w_win ? bus.b1_i : bus.b0_i;
`ifdef DIV_ZERO_BYPASS_EN
        w_bypass = (w_sel_b == 16'd0);
`else
        w_bypass = 1'b0;
`endif
    end

    always_comb begin
        w_state_nxt     = r_state;
        bus.ack_o       = 2'b00;
        bus.div_start_o = 1'b0;
        bus.rsp_valid_o = 1'b0;
        bus.busy_o      = (r_state != StIdle);
        case (r_state)
            StIdle: begin
                if (w_grant) begin
                    bus.ack_o   = w_win ? 2'b10 : 2'b01;
                    w_state_nxt = w_bypass ? StResp : StLaunch;
                end
            end
            StLaunch: begin
                bus.div_start_o = 1'b1;
                w_state_nxt     = StWait;
            end
            StWait: begin
                if (bus.div_ready_i) begin
                    w_state_nxt = StResp;
                end
            end
            StResp: begin
                bus.rsp_valid_o = 1'b1;
                w_state_nxt     = StIdle;
            end
            default: w_state_nxt = StIdle;
        endcase
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_state      <= StIdle;
            r_last_grant <= 1'b1;
            r_id         <= 1'b0;
            r_op_a       <= '0;
            r_op_b       <= '0;
            r_q          <= '0;
            r_r          <= '0;
`ifdef DIV_ZERO_BYPASS_EN
            r_dz         <= 1'b0;
`endif
        end else begin
            r_state <= w_state_nxt;
            if (w_grant) begin
                r_last_grant <= w_win;
                r_id         <= w_win;
                r_op_a       <= w_sel_a;
                r_op_b       <= w_sel_b;
`ifdef DIV_ZERO_BYPASS_EN
                if (w_bypass) begin
                    r_q  <= '1;
                    r_r  <= w_sel_a[15:0];
                    r_dz <= 1'b1;
                end
`endif
            end
            if ((r_state == StWait) && bus.div_ready_i) begin
                r_q  <= bus.div_q_i;
                r_r  <= bus.div_r_i;
`ifdef DIV_ZERO_BYPASS_EN
                r_dz <= 1'b0;
`endif
            end
        end
    end

    assign bus.rsp_id_o = r_id;
    assign bus.rsp_q_o  = r_q;
    assign bus.rsp_r_o  = r_r;
    assign bus.div_a_o  = r_op_a;
    assign bus.div_b_o  = r_op_b;
`ifdef DIV_ZERO_BYPASS_EN
    assign bus.rsp_dz_o = r_dz;
`else
    assign bus.rsp_dz_o = 1'b0;
`endif
endmodule
